// File: rtl/sonic_tx_ready_ctl.sv
// Per-channel TX readiness controller: start/stop hysteresis on the completed-qword count plus a fill timeout.
// Define SONIC_TX_UNDERRUN_CNT_EN to build the 16-bit saturating underrun counters.
module sonic_tx_ready_lane #(
  parameter int                WIDTH        = 14,
  parameter logic [WIDTH-1:0]  START_THRESH = 'h200,
  parameter logic [WIDTH-1:0]  STOP_THRESH  = '0,
  parameter int                FILL_TIMEOUT = 1024,
  parameter int                TMR_WIDTH    = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpl_valid,
  input  logic [WIDTH-1:0] cpl_qwords,
  input  logic             rdreq,
  input  logic             rdena,
  input  logic             fifo_empty,
  output logic             ready,
  output logic             cbuf_rdreq,
  output logic             cbuf_rdena,
  output logic [WIDTH-1:0] cpld_count,
  output logic             underrun,
  output logic [15:0]      underrun_count
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [TMR_WIDTH-1:0] TMO_LAST = TMR_WIDTH'(FILL_TIMEOUT - 1);

  state_t               state;
  logic [TMR_WIDTH-1:0] timer;
  logic                 grant, tmo_hit;

  assign grant      = rdreq & ready & ~fifo_empty;
  assign cbuf_rdreq = grant;
  assign cbuf_rdena = rdena & ready;
  assign tmo_hit    = (FILL_TIMEOUT != 0) && (timer == TMO_LAST);

  // A fresh snapshot already accounts for everything read before it, so only
  // the grant of the same cycle is taken off it.
  always_ff @(posedge clock) begin
    if (reset)
      cpld_count <= '0;
    else if (cpl_valid)
      cpld_count <= (cpl_qwords == '0) ? '0 : cpl_qwords - WIDTH'(grant);
    else if (grant)
      cpld_count <= (cpld_count == '0) ? '0 : cpld_count - WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      timer <= '0;
    end else begin
      timer <= '0;
      case (state)
        IDLE: if (cpld_count != '0) state <= FILL;
        FILL: begin
          if (cpld_count == '0) begin
            state <= IDLE;
          end else if (cpld_count >= START_THRESH || tmo_hit) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            timer <= (timer == '1) ? timer : timer + TMR_WIDTH'(1);
          end
        end
        RUN: begin
          if (cpld_count <= STOP_THRESH) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) underrun <= 1'b0;
    else       underrun <= rdreq & ready & fifo_empty;
  end

`ifdef SONIC_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      underrun_count <= '0;
    else if (underrun && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`else
  assign underrun_count = '0;
`endif
endmodule

module sonic_tx_ready_ctl #(
  parameter int                NCHAN        = 2,
  parameter int                WIDTH        = 14,
  parameter logic [WIDTH-1:0]  START_THRESH = 14'h200,
  parameter logic [WIDTH-1:0]  STOP_THRESH  = '0,
  parameter int                FILL_TIMEOUT = 1024,
  parameter int                TMR_WIDTH    = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCHAN-1:0]       cpl_valid,
  input  logic [NCHAN*WIDTH-1:0] cpl_qwords,
  input  logic [NCHAN-1:0]       rdreq,
  input  logic [NCHAN-1:0]       rdena,
  input  logic [NCHAN-1:0]       fifo_empty,
  output logic [NCHAN-1:0]       ready,
  output logic [NCHAN-1:0]       cbuf_rdreq,
  output logic [NCHAN-1:0]       cbuf_rdena,
  output logic [NCHAN*WIDTH-1:0] cpld_count,
  output logic [NCHAN-1:0]       underrun,
  output logic [NCHAN*16-1:0]    underrun_count
);
  if (START_THRESH <= STOP_THRESH) begin : g_bad_cfg
    $error("sonic_tx_ready_ctl: START_THRESH must exceed STOP_THRESH");
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_lane
    sonic_tx_ready_lane #(
      .WIDTH(WIDTH), .START_THRESH(START_THRESH), .STOP_THRESH(STOP_THRESH),
      .FILL_TIMEOUT(FILL_TIMEOUT), .TMR_WIDTH(TMR_WIDTH)
    ) u_lane (
      .clock          (clock),
      .reset          (reset),
      .cpl_valid      (cpl_valid[i]),
      .cpl_qwords     (cpl_qwords[i*WIDTH +: WIDTH]),
      .rdreq          (rdreq[i]),
      .rdena          (rdena[i]),
      .fifo_empty     (fifo_empty[i]),
      .ready          (ready[i]),
      .cbuf_rdreq     (cbuf_rdreq[i]),
      .cbuf_rdena     (cbuf_rdena[i]),
      .cpld_count     (cpld_count[i*WIDTH +: WIDTH]),
      .underrun       (underrun[i]),
      .underrun_count (underrun_count[i*16 +: 16])
    );
  end
endmodule

// File: tb/tb_sonic_tx_ready_ctl.sv
// Bench for sonic_tx_ready_ctl: directed scenarios with literal expectations, then random traffic vs a behavioural model.
module tb_sonic_tx_ready_ctl;
  localparam int NCHAN = 2, WIDTH = 14, START = 'h200, STOP = 0, TMO = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NCHAN-1:0]       cpl_valid = '0, rdreq = '0, rdena = '1, fifo_empty = '0;
  logic [NCHAN*WIDTH-1:0] cpl_qwords = '0;
  logic [NCHAN-1:0]       ready, cbuf_rdreq, cbuf_rdena, underrun;
  logic [NCHAN*WIDTH-1:0] cpld_count;
  logic [NCHAN*16-1:0]    underrun_count;

  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  sonic_tx_ready_ctl dut (
    .clock(clock), .reset(reset), .cpl_valid(cpl_valid), .cpl_qwords(cpl_qwords),
    .rdreq(rdreq), .rdena(rdena), .fifo_empty(fifo_empty), .ready(ready),
    .cbuf_rdreq(cbuf_rdreq), .cbuf_rdena(cbuf_rdena), .cpld_count(cpld_count),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a channel is either idle, filling (m_age = cycles spent
  // filling) or running (m_rdy); decisions use the count as it stood before the edge.
  int m_cnt[NCHAN], m_age[NCHAN], m_ucnt[NCHAN];
  bit m_rdy[NCHAN], m_und[NCHAN];

  initial for (int i = 0; i < NCHAN; i++) begin
    m_cnt[i] = 0; m_age[i] = -1; m_ucnt[i] = 0; m_rdy[i] = 0; m_und[i] = 0;
  end

  always @(posedge clock) begin
    for (int i = 0; i < NCHAN; i++) begin
      int c, q, g;
      c = m_cnt[i];
      q = int'(cpl_qwords[i*WIDTH +: WIDTH]);
      g = (rdreq[i] && m_rdy[i] && !fifo_empty[i]) ? 1 : 0;
      if (reset) begin
        m_cnt[i] = 0; m_age[i] = -1; m_ucnt[i] = 0; m_rdy[i] = 0; m_und[i] = 0;
      end else begin
`ifdef SONIC_TX_UNDERRUN_CNT_EN
        if (m_und[i] && m_ucnt[i] < 65535) m_ucnt[i]++;
`endif
        m_und[i] = rdreq[i] && m_rdy[i] && fifo_empty[i];
        if (cpl_valid[i])  m_cnt[i] = (q > g) ? q - g : 0;
        else if (g == 1)   m_cnt[i] = (c > 0) ? c - 1 : 0;
        if (m_rdy[i]) begin
          if (c <= STOP) m_rdy[i] = 0;
        end else if (m_age[i] < 0) begin
          if (c != 0) m_age[i] = 0;
        end else if (c == 0) begin
          m_age[i] = -1;
        end else if (c >= START || (TMO != 0 && m_age[i] == TMO - 1)) begin
          m_rdy[i] = 1; m_age[i] = -1;
        end else if (m_age[i] < 2047) begin
          m_age[i]++;
        end
      end
    end
    #1;
    for (int i = 0; i < NCHAN; i++) begin
      chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(m_rdy[i]));
      chk($sformatf("cbuf_rdreq[%0d]", i), 32'(cbuf_rdreq[i]),
          32'(rdreq[i] && m_rdy[i] && !fifo_empty[i]));
      chk($sformatf("cbuf_rdena[%0d]", i), 32'(cbuf_rdena[i]), 32'(rdena[i] && m_rdy[i]));
      chk($sformatf("cpld_count[%0d]", i), 32'(cpld_count[i*WIDTH +: WIDTH]), 32'(m_cnt[i]));
      chk($sformatf("underrun[%0d]", i), 32'(underrun[i]), 32'(m_und[i]));
      chk($sformatf("underrun_count[%0d]", i), 32'(underrun_count[i*16 +: 16]), 32'(m_ucnt[i]));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic cpl(input int ch, input int q);
    cpl_valid[ch] = 1'b1;
    cpl_qwords[ch*WIDTH +: WIDTH] = WIDTH'(q);
    tick();
    cpl_valid[ch] = 1'b0;
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(cpld_count[ch*WIDTH +: WIDTH]);
  endfunction

  initial begin
    int n, nur;
    logic [31:0] exp_ucnt;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst ready", 32'(ready), 0);
    chk("rst cpld_count", 32'(cpld_count), 0);
    chk("rst underrun_count", underrun_count, 0);

    // Below-threshold completion only fills; reaching the threshold starts one edge later.
    cpl(0, 'h1FF);
    chk("fill cnt", cnt(0), 'h1FF);
    chk("fill ready", 32'(ready[0]), 0);
    tick();
    chk("fill ready2", 32'(ready[0]), 0);
    cpl(0, 'h200);
    chk("start cnt", cnt(0), 'h200);
    chk("start ready pre", 32'(ready[0]), 0);
    tick();
    chk("start ready", 32'(ready[0]), 1);

    // Drain to zero; ready falls one edge after the count hits zero.
    cpl(0, 3);
    chk("drain cnt3", cnt(0), 3);
    rdreq[0] = 1'b1;
    tick(); chk("drain cnt2", cnt(0), 2);
    tick(); chk("drain cnt1", cnt(0), 1);
    tick(); chk("drain cnt0", cnt(0), 0);
    chk("drain ready still", 32'(ready[0]), 1);
    tick();
    chk("drain ready off", 32'(ready[0]), 0);
    chk("drain cbuf_rdreq", 32'(cbuf_rdreq[0]), 0);
    chk("drain cnt stays", cnt(0), 0);
    rdreq[0] = 1'b0;

    // Fill timeout on ch1: enter FILL one edge after the load, start 1024 edges later.
    cpl(1, 5);
    n = 0;
    while (!ready[1] && n < 2000) begin
      tick(); n++;
    end
    chk("timeout edges", n, TMO + 1);
    chk("timeout ch0 ready", 32'(ready[0]), 0);
    chk("timeout ch1 cnt", cnt(1), 5);

    // Same-cycle completion and grant.
    cpl(0, 'h300); tick(); tick();
    chk("run ready", 32'(ready[0]), 1);
    rdreq[0] = 1'b1;
    cpl(0, 'h300);
    chk("cpl+grant", cnt(0), 'h2FF);
    cpl(0, 0);
    chk("cpl0+grant", cnt(0), 0);
    rdreq[0] = 1'b0;
    tick();

    // Underrun: three requests against an empty FIFO while running.
    cpl(0, 'h300); tick(); tick();
    chk("ur ready", 32'(ready[0]), 1);
    rdreq[0] = 1'b1; fifo_empty[0] = 1'b1;
    nur = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nur += int'(underrun[0]);
      chk("ur cbuf_rdreq", 32'(cbuf_rdreq[0]), 0);
    end
    rdreq[0] = 1'b0; fifo_empty[0] = 1'b0;
    tick();
    chk("ur pulses", nur, 3);
    chk("ur pulse off", 32'(underrun[0]), 0);
`ifdef SONIC_TX_UNDERRUN_CNT_EN
    exp_ucnt = 3;
`else
    exp_ucnt = 0;
`endif
    chk("ur count", 32'(underrun_count[15:0]), exp_ucnt);
    chk("ur cnt kept", cnt(0), 'h300);

    // Reset mid-run.
    cpl(0, 'h150);
    chk("pre-rst cnt", cnt(0), 'h150);
    chk("pre-rst ready", 32'(ready[0]), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post-rst ready", 32'(ready), 0);
    chk("post-rst cnt", cnt(0), 0);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NCHAN; i++) begin
        int r;
        cpl_valid[i]  = ($urandom_range(0, 19) == 0);
        r = $urandom_range(0, 3);
        case (r)
          0:       cpl_qwords[i*WIDTH +: WIDTH] = '0;
          1:       cpl_qwords[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 7));
          2:       cpl_qwords[i*WIDTH +: WIDTH] = WIDTH'($urandom_range('h1F0, 'h20F));
          default: cpl_qwords[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 16383));
        endcase
        rdreq[i]      = ($urandom_range(0, 3) != 0);
        fifo_empty[i] = ($urandom_range(0, 7) == 0);
        rdena[i]      = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    reset = 1'b0; cpl_valid = '0; rdreq = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
